// File: rtl/wallace_mult_pipe.sv
// -----------------------------------------------------------------------------
// wallace_mult_pipe
//
// Pipelined Wallace-tree multiplier with a per-operation signed/unsigned mode
// and valid/ready flow control. This is the shared multiply datapath for the
// arithmetic units.
//
// Parameters
//   WIDTH  : operand width in bits (8, 16, 32 or 64)
//   STAGES : pipeline registers between accept and out_valid (1..4)
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous active-high reset (control state and p)
//   in_valid    operand pair present on a, b, signed_mode
//   in_ready    block accepts this cycle (combinational from out_valid/out_ready)
//   signed_mode 1 = two's-complement operands, 0 = unsigned
//   a, b        multiplicand / multiplier
//   out_valid   p holds a valid product
//   out_ready   consumer accepts p
//   p           low 2*WIDTH bits of the exact product
//
// Structure
//   Operands are extended to WIDTH+1 bits (sign or zero). WIDTH partial-product
//   rows come from the low bits of b; the extended sign bit of b carries
//   negative weight, so its row is added as the one's complement of
//   (a << WIDTH) plus a +1 correction row. That gives WIDTH+2 rows, which are
//   reduced by row-wise 3:2 carry-save layers down to two rows, then summed by
//   a carry-propagate adder into p. The CSA layers are split across the
//   pipeline stages as evenly as possible; stage 0 also forms the partial
//   products and the last stage also holds the final adder.
// -----------------------------------------------------------------------------
module wallace_mult_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   p
);

  localparam int PW  = 2 * WIDTH;   // product width
  localparam int NPP = WIDTH + 2;   // partial-product rows incl. sign correction

  typedef logic [NPP-1:0][PW-1:0] rows_t;

  // Row count left after k row-wise 3:2 layers starting from NPP rows.
  function automatic int rows_after(input int k);
    int n;
    n = NPP;
    for (int l = 0; l < 64; l++) begin
      if (l < k) n = 2 * (n / 3) + (n % 3);
    end
    return n;
  endfunction

  // Number of 3:2 layers needed to bring NPP rows down to two.
  function automatic int count_layers(input int rows);
    int n;
    int l;
    n = rows;
    l = 0;
    for (int i = 0; i < 64; i++) begin
      if (n > 2) begin
        n = 2 * (n / 3) + (n % 3);
        l = l + 1;
      end
    end
    return l;
  endfunction

  localparam int LAYERS     = count_layers(NPP);
  localparam int FINAL_ROWS = rows_after(LAYERS);

  // First CSA layer owned by stage s; stage s runs layers [bound(s), bound(s+1)).
  function automatic int bound(input int s);
    return (LAYERS * s) / STAGES;
  endfunction

  // Apply CSA layers lo..hi-1 to a row set. The running row count is tracked
  // from the tree input so a stage starting mid-tree knows how many rows are
  // live. Rows beyond the live count are always zero.
  function automatic rows_t csa_layers(input rows_t in_rows, input int lo, input int hi);
    rows_t cur;
    rows_t nxt;
    int    n;
    int    g;
    cur = in_rows;
    n   = NPP;
    for (int l = 0; l < LAYERS; l++) begin
      g = n / 3;
      if (l >= lo && l < hi) begin
        nxt = '0;
        for (int i = 0; i < NPP; i++) begin
          if (i < g) begin
            nxt[2*i]   = cur[3*i] ^ cur[3*i+1] ^ cur[3*i+2];
            nxt[2*i+1] = ((cur[3*i]   & cur[3*i+1]) |
                          (cur[3*i]   & cur[3*i+2]) |
                          (cur[3*i+1] & cur[3*i+2])) << 1;
          end else if (i >= 3 * g && i < n) begin
            // Leftover rows that did not fill a 3:2 group pass straight down.
            nxt[i-g] = cur[i];
          end
        end
        cur = nxt;
      end
      n = 2 * g + (n % 3);
    end
    return cur;
  endfunction

  // Whole pipeline moves together; a stalled output freezes every stage.
  logic advance;
  assign advance  = !(out_valid && !out_ready);
  assign in_ready = advance;

  logic              out_valid_q;
  logic [PW-1:0]     p_q;
  assign out_valid = out_valid_q;
  assign p         = p_q;

  // ---------------------------------------------------------------------------
  // Partial-product generation (combinational front of stage 0)
  // ---------------------------------------------------------------------------
  logic signed [WIDTH:0]  a_ext;
  logic signed [WIDTH:0]  b_ext;
  logic signed [PW-1:0]   a_wide;
  rows_t                  pp_rows;

  always_comb begin
    a_ext   = {signed_mode & a[WIDTH-1], a};
    b_ext   = {signed_mode & b[WIDTH-1], b};
    a_wide  = {{(WIDTH-1){a_ext[WIDTH]}}, a_ext};
    pp_rows = '0;
    for (int j = 0; j < WIDTH; j++) begin
      pp_rows[j] = b_ext[j] ? (a_wide << j) : '0;
    end
    // -(a << WIDTH) = ~(a << WIDTH) + 1, split into a row and a +1 row.
    pp_rows[WIDTH]   = b_ext[WIDTH] ? ~(a_wide << WIDTH) : '0;
    pp_rows[WIDTH+1] = {{(PW-1){1'b0}}, b_ext[WIDTH]};
  end

  // ---------------------------------------------------------------------------
  // Pipeline stages
  // ---------------------------------------------------------------------------
  for (genvar s = 0; s < STAGES; s++) begin : g_st
    rows_t in_rows;
    rows_t rows_d;
    logic  vld_in;

    if (s == 0) begin : g_src
      assign in_rows = pp_rows;
      assign vld_in  = in_valid;
    end else begin : g_src
      assign in_rows = g_st[s-1].g_reg.rows_q;
      assign vld_in  = g_st[s-1].g_reg.vld_q;
    end

    assign rows_d = csa_layers(in_rows, bound(s), bound(s + 1));

    if (s < STAGES - 1) begin : g_reg
      // ---- stage boundary: carry-save rows registered ----
      rows_t rows_q;
      logic  vld_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          vld_q <= 1'b0;
        end else if (advance) begin
          vld_q <= vld_in;
        end
      end

      always_ff @(posedge clk) begin
        if (advance) begin
          rows_q <= rows_d;
        end
      end
    end else begin : g_out
      // ---- final boundary: carry-propagate add into p ----
      logic [PW-1:0] p_d;

      always_comb begin
        p_d = '0;
        for (int i = 0; i < NPP; i++) begin
          if (i < FINAL_ROWS) p_d = p_d + rows_d[i];
        end
      end

      // p only loads on a valid result so it keeps its value across bubbles.
      always_ff @(posedge clk) begin
        if (rst) begin
          out_valid_q <= 1'b0;
          p_q         <= '0;
        end else if (advance) begin
          out_valid_q <= vld_in;
          if (vld_in) p_q <= p_d;
        end
      end
    end
  end

endmodule

// File: doc/wallace_mult_pipe.md
Name: wallace_mult_pipe

Overview:
Parametrised, pipelined Wallace-tree multiplier and successor to the fixed 32-bit single-latency multiplier. It adds:
- configurable operand width and pipeline depth;
- a per-operation signed/unsigned mode;
- valid/ready flow control with backpressure.

It sits in the multipliers group as the shared multiply datapath for the chip's arithmetic units.

Parameters:
- WIDTH, 32, operand width in bits. Legal values are 8, 16, 32, 64.
- STAGES, 3, number of pipeline registers from accept to out_valid. Range 1..4.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  operand pair present
- in_ready  output  1  block accepts this cycle
- signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; sampled with a, b
- a  input  WIDTH  multiplicand
- b  input  WIDTH  multiplier
- out_valid  output  1  p holds a valid product
- out_ready  input  1  consumer accepts p
- p  output  2*WIDTH  product

Behaviour:
- Reset (sync, active-high, checked at posedge clk):
  - all stage valid bits, out_valid and p clear to 0;
  - in_ready reads 1 in the cycle after reset;
  - in-flight operations are discarded, with no partial output.
- Accept: an operation is accepted on a posedge with in_valid && in_ready. a, b and signed_mode are captured together.
- Advance: advance = !(out_valid && !out_ready). The whole pipeline moves only when advance = 1; when advance = 0 every stage register holds. in_ready = advance, which is combinational from out_valid and out_ready.
- Bubbles: a bubble (in_valid = 0 on an advance cycle) propagates as a cleared valid bit. Bubbles are not collapsed.
- Latency: out_valid asserts exactly STAGES advancing cycles after accept. With out_ready held at 1, the block sustains throughput of 1 result per cycle.
- Operand extension:
  - operands are extended to WIDTH+1 bits: sign bit when signed_mode = 1, zero when signed_mode = 0;
  - partial products are formed from the extended operands with sign-correction rows;
  - p = low 2*WIDTH bits of the exact product. This is exact for both modes; no overflow is possible.
- Stage split:
  - stage 1: partial-product generation plus 3:2 CSA layers;
  - middle stages: continue Wallace 3:2/2:2 reduction on sum/carry vectors;
  - final stage: 2*WIDTH carry-propagate add into the p register.
  - With STAGES = 1 the whole tree plus CPA sits before a single register. The CSA layer split is balanced to within one layer per stage.
- Output hold: p and out_valid stay stable while out_valid && !out_ready. p changes only on an advancing edge. p keeps its last value when out_valid falls, and it is don't-care for checking while out_valid = 0.
- Mode mixing: signed_mode travels with each operation. Mixed modes back-to-back are legal and produce no interaction between operations.
- Simultaneous events:
  - rst wins over in_valid, out_ready and advance;
  - output handoff and new accept in the same cycle are legal and lose no data.
- Corner operands:
  - 0 times anything gives 0;
  - signed most-negative times most-negative gives exactly 2^(2*WIDTH-2);
  - unsigned all-ones squared gives 2^(2*WIDTH) - 2^(WIDTH+1) + 1.

Test Plan:
1. WIDTH = 32, STAGES = 3, out_ready = 1. Send 20*75 unsigned, then signed 0xFFFFFFD5*0xFFFFFFD0 on back-to-back cycles. Required: p = 1500 and then p = 64'h810 (2064) on consecutive cycles, the first arriving 3 cycles after accept.
2. Signed 23*0xFFFFFFF1 gives 64'hFFFFFFFFFFFFFEA7. Signed 0xFFFFFFE7*30 gives 64'hFFFFFFFFFFFFFD12. Signed 125*0xFFFFFFEE gives 64'hFFFFFFFFFFFFF736.
3. Mode corners:
   - 0xFFFFFFFF squared unsigned gives 64'hFFFFFFFE00000001; signed gives 64'h1;
   - 0x80000000 squared signed gives 64'h4000000000000000;
   - 10*0 gives 0; 10*1 gives 10.
4. Backpressure: stream 4 ops (k*k, k = 1..4) with out_ready low for 5 cycles after the first out_valid. Required: in_ready = 0 while stalled, p holds 1 throughout the stall, then 1, 4, 9, 16 are delivered in order with no loss or duplication.
5. Reset mid-flight: accept 3 ops, assert rst for 1 cycle before any out_valid. Required: out_valid stays 0 and none of the 3 ops emerges. A new op 6*7 accepted afterwards gives p = 42 after STAGES cycles.
6. Sweep WIDTH in {8, 16, 64} and STAGES in {1, 4} with 1000 random ops per configuration in mixed modes against a reference product. Required: zero mismatches, and latency equals STAGES for every configuration.
